// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP datapath stages: FSM state encoding,
// accumulator sizing and the saturate-to-DATA_WIDTH helpers.
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  // Width of the wide signed values handed to the saturation helpers.
  // Any accumulator up to this width is sign-extended into it by the caller.
  localparam int SAT_W = 128;

  // Accumulator width that cannot overflow over n products of two
  // data_width-bit signed operands (plus a pre-loaded bias).
  function automatic int acc_width(input int data_width, input int n);
    return 2 * data_width + $clog2(n) + 1;
  endfunction

  // Largest value representable in a dw-bit signed word.
  function automatic logic signed [SAT_W-1:0] sat_max(input int dw);
    logic signed [SAT_W-1:0] one;
    one = 1;
    return (one <<< (dw - 1)) - one;
  endfunction

  // Smallest value representable in a dw-bit signed word.
  function automatic logic signed [SAT_W-1:0] sat_min(input int dw);
    logic signed [SAT_W-1:0] one;
    one = 1;
    return -sat_max(dw) - one;
  endfunction

  // Clamp x into the dw-bit signed range; the caller keeps the low dw bits.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] x,
                                                       input int dw);
    if (x > sat_max(dw)) return sat_max(dw);
    if (x < sat_min(dw)) return sat_min(dw);
    return x;
  endfunction

  // True when saturate() would change x.
  function automatic logic is_clipped(input logic signed [SAT_W-1:0] x, input int dw);
    return (x > sat_max(dw)) || (x < sat_min(dw));
  endfunction

endpackage

// File: rtl/mlp_tile_sum.sv
// Combinational tile reduction: SIZE parallel full-precision signed
// multiplies followed by a balanced binary adder tree.
module mlp_tile_sum #(
  parameter  int SIZE       = 4,
  parameter  int DATA_WIDTH = 16,
  localparam int SUM_WIDTH  = 2 * DATA_WIDTH + $clog2(SIZE) + 1
) (
  input  logic signed [DATA_WIDTH-1:0] data_in    [SIZE],
  input  logic signed [DATA_WIDTH-1:0] weights_in [SIZE],
  output logic signed [SUM_WIDTH-1:0]  sum_out
);

  // Tree is padded to a power of two; unused leaves contribute zero.
  localparam int LEVELS = $clog2(SIZE);
  localparam int LEAVES = 1 << LEVELS;

  // Heap layout: node[0] is the root, leaves start at LEAVES-1.
  logic signed [SUM_WIDTH-1:0] node [2*LEAVES-1];

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < SIZE) begin : g_prod
      logic signed [2*DATA_WIDTH-1:0] prod;
      // Operands are widened first so the product keeps all 2*DATA_WIDTH bits.
      assign prod = (2*DATA_WIDTH)'(data_in[i]) * (2*DATA_WIDTH)'(weights_in[i]);
      assign node[LEAVES-1+i] = SUM_WIDTH'(prod);
    end else begin : g_pad
      assign node[LEAVES-1+i] = '0;
    end
  end

  for (genvar n = 0; n < LEAVES - 1; n++) begin : g_add
    assign node[n] = node[2*n+1] + node[2*n+2];
  end

  assign sum_out = node[0];

endmodule

// File: rtl/mlp_tiled_vector_dot.sv
// One MLP neuron: bias + sum(data*weight) over NUM_TILES tiles of SIZE
// elements, accumulated at full precision, rescaled by FRACTION_WIDTH and
// saturated to DATA_WIDTH.
// Build option: define MLP_RELU_EN to clamp negative results to zero.
module mlp_tiled_vector_dot
  import mlp_pkg::*;
#(
  parameter int SIZE           = 4,
  parameter int NUM_TILES      = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int FRACTION_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic signed [DATA_WIDTH-1:0] bias_in,
  input  logic signed [DATA_WIDTH-1:0] data_in    [SIZE],
  input  logic signed [DATA_WIDTH-1:0] weights_in [SIZE],
  input  logic                         tile_valid,
  output logic                         tile_ready,
  output logic                         busy,
  output logic signed [DATA_WIDTH-1:0] result_out,
  output logic                         finished_out,
  output logic                         sat_out
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, SIZE * NUM_TILES);
  localparam int SUM_WIDTH = 2 * DATA_WIDTH + $clog2(SIZE) + 1;
  localparam int CNT_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [CNT_W-1:0] LAST_TILE = CNT_W'(NUM_TILES - 1);

  state_e                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]              tile_cnt_q, tile_cnt_d;
  logic signed [DATA_WIDTH-1:0]  result_q, result_d;
  logic                          finished_q, finished_d;
  logic                          sat_q, sat_d;

  logic signed [SUM_WIDTH-1:0]   tile_sum;
  logic signed [ACC_WIDTH-1:0]   scaled;
  logic signed [SAT_W-1:0]       final_wide;

  mlp_tile_sum #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tile_sum (
    .data_in    (data_in),
    .weights_in (weights_in),
    .sum_out    (tile_sum)
  );

  // Rescale the accumulator (floor) and apply the optional ReLU clamp.
  always_comb begin
    scaled     = acc_q >>> FRACTION_WIDTH;
    final_wide = SAT_W'(scaled);
`ifdef MLP_RELU_EN
    if (final_wide < 0) final_wide = '0;
`endif
  end

  // Next-state logic for the IDLE -> ACCUM -> OUTPUT sequence.
  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    tile_cnt_d = tile_cnt_q;
    result_d   = result_q;
    sat_d      = sat_q;
    finished_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          acc_d      = ACC_WIDTH'(bias_in) <<< FRACTION_WIDTH;
          tile_cnt_d = '0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        // tile_ready is 1 throughout ACCUM, so tile_valid alone accepts.
        if (tile_valid) begin
          acc_d      = acc_q + ACC_WIDTH'(tile_sum);
          tile_cnt_d = tile_cnt_q + 1'b1;
          if (tile_cnt_q == LAST_TILE) state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        result_d   = DATA_WIDTH'(saturate(final_wide, DATA_WIDTH));
        sat_d      = is_clipped(final_wide, DATA_WIDTH);
        finished_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      tile_cnt_q <= '0;
      result_q   <= '0;
      sat_q      <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      tile_cnt_q <= tile_cnt_d;
      result_q   <= result_d;
      sat_q      <= sat_d;
      finished_q <= finished_d;
    end
  end

  // Handshake and status outputs decode the registered state only.
  assign tile_ready   = (state_q == ACCUM);
  assign busy         = (state_q != IDLE);
  assign result_out   = result_q;
  assign sat_out      = sat_q;
  assign finished_out = finished_q;

endmodule

// File: tb/tb_mlp_tiled_vector_dot.sv
// Self-checking bench for mlp_tiled_vector_dot (default Q8.8, 4x3 tiles).
// Honours MLP_RELU_EN in its expectations.
module tb_mlp_tiled_vector_dot;

  localparam int SZ = 4;
  localparam int NT = 3;
  localparam int DW = 16;
  localparam int FW = 8;

  typedef struct {
    logic signed [DW-1:0] bias;
    logic signed [DW-1:0] d [NT][SZ];
    logic signed [DW-1:0] w [NT][SZ];
    logic signed [DW-1:0] exp_res;
    logic                 exp_sat;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 run;
  logic signed [DW-1:0] bias_in;
  logic signed [DW-1:0] data_in    [SZ];
  logic signed [DW-1:0] weights_in [SZ];
  logic                 tile_valid;
  logic                 tile_ready;
  logic                 busy;
  logic signed [DW-1:0] result_out;
  logic                 finished_out;
  logic                 sat_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0_cyc = 0;
  int fin_count = 0;

  mlp_tiled_vector_dot #(
    .SIZE           (SZ),
    .NUM_TILES      (NT),
    .DATA_WIDTH     (DW),
    .FRACTION_WIDTH (FW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .bias_in      (bias_in),
    .data_in      (data_in),
    .weights_in   (weights_in),
    .tile_valid   (tile_valid),
    .tile_ready   (tile_ready),
    .busy         (busy),
    .result_out   (result_out),
    .finished_out (finished_out),
    .sat_out      (sat_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (finished_out) fin_count <= fin_count + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer dot product, floor rescale, optional ReLU, clamp.
  function automatic void model(input vec_t v, output logic signed [DW-1:0] r, output logic s);
    longint acc;
    longint scaled;
    longint hi;
    longint lo;
    hi  = (longint'(1) << (DW - 1)) - 1;
    lo  = -(longint'(1) << (DW - 1));
    acc = longint'(v.bias) * (longint'(1) << FW);
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < SZ; i++)
        acc += longint'(v.d[t][i]) * longint'(v.w[t][i]);
    scaled = acc >>> FW;
`ifdef MLP_RELU_EN
    if (scaled < 0) scaled = 0;
`endif
    s = 1'b0;
    if (scaled > hi) begin scaled = hi; s = 1'b1; end
    else if (scaled < lo) begin scaled = lo; s = 1'b1; end
    r = DW'(scaled);
  endfunction

  function automatic vec_t fill(input logic signed [DW-1:0] b, input logic signed [DW-1:0] dv,
                                input logic signed [DW-1:0] wv, input logic signed [DW-1:0] er,
                                input logic es);
    vec_t v;
    v.bias = b;
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < SZ; i++) begin
        v.d[t][i] = dv;
        v.w[t][i] = wv;
      end
    v.exp_res = er;
    v.exp_sat = es;
    return v;
  endfunction

  task automatic junk_tile();
    for (int i = 0; i < SZ; i++) begin
      data_in[i]    = DW'($urandom);
      weights_in[i] = DW'($urandom);
    end
  endtask

  // Called at a negedge in IDLE; leaves the DUT in ACCUM just after E0.
  task automatic start_run(input logic signed [DW-1:0] b);
    run     = 1'b1;
    bias_in = b;
    @(posedge clk);
    @(negedge clk);
    run     = 1'b0;
    bias_in = DW'($urandom);
    e0_cyc  = cyc;
    check("busy_after_run", busy, 1);
    check("ready_after_run", tile_ready, 1);
  endtask

  // Feed all tiles (optional stall before tile 1), wait for finished_out and
  // optionally issue the next run on the finishing cycle.
  task automatic feed(input vec_t v, input int gap, input bit run_in_gap, input bit chain,
                      input logic signed [DW-1:0] chain_bias, input string tag);
    int n;
    int lat;
    int fin_before;
    fin_before = fin_count;
    for (int t = 0; t < NT; t++) begin
      if (t == 1 && gap > 0) begin
        tile_valid = 1'b0;
        junk_tile();
        for (int g = 0; g < gap; g++) begin
          run     = run_in_gap && (g == 1);
          bias_in = DW'($urandom);
          @(posedge clk);
          @(negedge clk);
        end
        run = 1'b0;
        check({tag, "_busy_in_stall"}, busy, 1);
      end
      data_in    = v.d[t];
      weights_in = v.w[t];
      tile_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    tile_valid = 1'b0;
    junk_tile();
    n = 0;
    while (!finished_out && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!finished_out) check({tag, "_finish_timeout"}, 0, 1);
    lat = cyc - e0_cyc;
    check({tag, "_result"}, result_out, v.exp_res);
    check({tag, "_sat"}, sat_out, v.exp_sat);
    check({tag, "_latency"}, lat, NT + 1 + gap);
    check({tag, "_busy_at_finish"}, busy, 0);
    if (chain) begin
      start_run(chain_bias);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, "_one_pulse"}, finished_out, 0);
    check({tag, "_pulse_count"}, fin_count - fin_before, 1);
  endtask

  vec_t tbl [7];
  vec_t v;
  int   fin_snap;

  initial begin
    tbl[0] = fill(64, 256, 128, 1600, 1'b0);
    tbl[1] = fill(32767, 32767, 32767, 32767, 1'b1);
`ifdef MLP_RELU_EN
    tbl[2] = fill(32767, 32767, -32767, 0, 1'b0);
    tbl[3] = fill(0, -256, 128, 0, 1'b0);
`else
    tbl[2] = fill(32767, 32767, -32767, -32768, 1'b1);
    tbl[3] = fill(0, -256, 128, -1536, 1'b0);
`endif
    tbl[4] = fill(0, 0, 0, 0, 1'b0);
    tbl[4].d[0][0] = 1;
    tbl[4].w[0][0] = 1;
    tbl[5] = fill(0, 0, 0, 0, 1'b0);
    tbl[5].d[0][0] = 1;
    tbl[5].w[0][0] = -1;
`ifdef MLP_RELU_EN
    tbl[5].exp_res = 0;
`else
    tbl[5].exp_res = -1;
`endif
    tbl[6] = fill(-100, 0, 0, -100, 1'b0);
`ifdef MLP_RELU_EN
    tbl[6].exp_res = 0;
`endif

    reset      = 1'b1;
    run        = 1'b0;
    bias_in    = '0;
    tile_valid = 1'b0;
    junk_tile();
    repeat (3) @(negedge clk);
    check("rst_result", result_out, 0);
    check("rst_finished", finished_out, 0);
    check("rst_sat", sat_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", tile_ready, 0);
    reset = 1'b0;
    @(negedge clk);

    // Tiles offered while idle are ignored.
    tile_valid = 1'b1;
    repeat (3) begin
      junk_tile();
      @(posedge clk);
      @(negedge clk);
      check("idle_ready_low", tile_ready, 0);
      check("idle_busy_low", busy, 0);
    end
    tile_valid = 1'b0;

    // Table vectors, back-to-back tiles.
    for (int k = 0; k < 7; k++) begin
      start_run(tbl[k].bias);
      feed(tbl[k], 0, 1'b0, 1'b0, 0, $sformatf("tbl%0d", k));
    end

    // Stall of 3 cycles between tiles with a stray run pulse in the stall.
    start_run(tbl[0].bias);
    feed(tbl[0], 3, 1'b1, 1'b0, 0, "stall");

    // run on the finished_out cycle is accepted immediately.
    start_run(tbl[3].bias);
    feed(tbl[3], 0, 1'b0, 1'b1, tbl[0].bias, "chainA");
    feed(tbl[0], 0, 1'b0, 1'b0, 0, "chainB");

    // Reset after tile 1: aborted run never finishes, result reads 0.
    start_run(tbl[1].bias);
    for (int t = 0; t < 2; t++) begin
      data_in    = tbl[1].d[t];
      weights_in = tbl[1].w[t];
      tile_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    tile_valid = 1'b0;
    fin_snap   = fin_count;
    reset      = 1'b1;
    #1;
    check("abort_result", result_out, 0);
    check("abort_sat", sat_out, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", tile_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_pulse", fin_count - fin_snap, 0);
    check("abort_result_idle", result_out, 0);
    start_run(tbl[0].bias);
    feed(tbl[0], 0, 1'b0, 1'b0, 0, "after_abort");

    // Randomised operations against the reference model.
    for (int k = 0; k < 12; k++) begin
      v.bias = DW'($urandom);
      for (int t = 0; t < NT; t++)
        for (int i = 0; i < SZ; i++) begin
          if (k % 3 == 0) begin
            v.d[t][i] = DW'($urandom);
            v.w[t][i] = DW'($urandom);
          end else begin
            v.d[t][i] = DW'(int'($urandom_range(0, 2047)) - 1024);
            v.w[t][i] = DW'(int'($urandom_range(0, 511)) - 256);
          end
        end
      if (k % 3 == 1) v.bias = DW'(int'($urandom_range(0, 511)) - 256);
      model(v, v.exp_res, v.exp_sat);
      start_run(v.bias);
      feed(v, int'($urandom_range(0, 2)), 1'b1, 1'b0, 0, $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlp_tiled_vector_dot.md
# mlp_tiled_vector_dot

Parametrised successor to the MLP complete-vector-dot stage. It computes one neuron output, bias + Σ data·weight, over a vector of SIZE·NUM_TILES elements, fed as NUM_TILES tiles of SIZE elements through a valid/ready handshake. It keeps a full-precision accumulator, rescales the fixed-point result once at the end, and saturates it to DATA_WIDTH. It sits between the layer controller, which streams tiles from weight/activation buffers, and the activation/output buffer of each MLP layer.

## Interface
- SIZE, 4, elements per tile (≥1)
- NUM_TILES, 3, tiles per output (≥1)
- DATA_WIDTH, 16, signed fixed-point width of data, weights, bias and result
- FRACTION_WIDTH, 8, fractional bits of every DATA_WIDTH operand
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- run  in  1  start pulse; sampled only in IDLE
- bias_in  in  DATA_WIDTH  signed bias; sampled on the cycle run is accepted
- data_in  in  SIZE×DATA_WIDTH  signed tile data, unpacked array [SIZE]
- weights_in  in  SIZE×DATA_WIDTH  signed tile weights, unpacked array [SIZE]
- tile_valid  in  1  data_in/weights_in hold a valid tile
- tile_ready  out  1  block accepts a tile this cycle
- busy  out  1  state ≠ IDLE
- result_out  out  DATA_WIDTH  signed saturated result; holds its value until the next completion
- finished_out  out  1  one-cycle pulse when result_out updates
- sat_out  out  1  result_out was clipped; updates with result_out

## Operation
- ACC_WIDTH = 2·DATA_WIDTH + clog2(SIZE·NUM_TILES) + 1, signed. The accumulator cannot overflow internally.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE: when run=1, acc ← sign-extended bias_in << FRACTION_WIDTH, tile_cnt ← 0, go to ACCUM.
- ACCUM: tile_ready=1. A tile is accepted when tile_valid && tile_ready.
  - On acceptance: acc ← acc + Σ data_in[i]·weights_in[i], using full-precision 2·DATA_WIDTH products. tile_cnt increments.
  - If the accepted tile was tile NUM_TILES−1, go to OUTPUT.
  - tile_valid=0 stalls the block indefinitely with no state change.
- OUTPUT: scaled = acc >>> FRACTION_WIDTH (arithmetic shift, rounds toward −∞).
  - If scaled > 2^(DATA_WIDTH−1)−1 or scaled < −2^(DATA_WIDTH−1): result_out ← the bound, sat_out ← 1. Otherwise result_out ← scaled, sat_out ← 0.
  - finished_out ← 1; go to IDLE.
- tile_ready is 0 in IDLE and OUTPUT. Tiles presented there are ignored.
- run while busy is ignored. It does not restart or corrupt the current operation.
- run on the same cycle finished_out is high: the FSM is already in IDLE, so run is accepted.

## Timing
- Reset values: result_out=0, finished_out=0, sat_out=0, busy=0, tile_ready=0, state=IDLE, acc=0, tile_cnt=0.
- run accepted at edge E0: busy and tile_ready are high from E0.
- With tile_valid held high, tiles are accepted at edges E1…E_NUM_TILES. The OUTPUT edge is E_NUM_TILES+1, where result_out, sat_out and finished_out update and busy falls. Minimum total is NUM_TILES+2 cycles from run to finished_out.
- finished_out is high for exactly one cycle per operation.
- Reset asserted mid-operation: immediate return to reset values. No finished_out pulse; the partial result is discarded.
- tile_ready is a registered state decode with no combinational path from tile_valid.

## Configuration
- MLP_RELU_EN defined: in OUTPUT, a negative scaled result is forced to 0 before saturation, and sat_out is 0 in that case. Positive results behave identically in both builds.
- MLP_RELU_EN undefined: signed result as specified above.

## Structure
- Shared package mlp_pkg holds:
  - the state enum (IDLE/ACCUM/OUTPUT)
  - an acc_width(data_width, n) function
  - a saturate-to-DATA_WIDTH function reused by other MLP stages
- One combinational sub-module, mlp_tile_sum: SIZE parallel signed multiplies plus an adder tree. It outputs a signed sum of width 2·DATA_WIDTH + clog2(SIZE) + 1. The top level holds the FSM, accumulator, rescale and saturation.

## Test plan
Defaults (Q8.8):
- All data=256 (1.0), weights=128 (0.5), bias=64, back-to-back tiles → result_out=1600 (6.25), sat_out=0, finished_out at run+5 cycles for exactly one cycle.
- All data=32767, weights=32767, bias=32767 → result_out=32767, sat_out=1. Same magnitudes with weights=−32767 → −32768, sat_out=1.
- Data=−256, weights=128, bias=0 → −1536; with MLP_RELU_EN → 0, sat_out=0.
- One element data=1, weight=1, all others 0 → 0. With weight=−1 → −1 (floor rounding).
- Drop tile_valid for 3 cycles between tiles, and pulse run during ACCUM → result unchanged (1600), finished_out delayed by 3 cycles, exactly one pulse.
- Assert reset after tile 1, then run a full operation → no finished_out from the aborted run; second result correct, and result_out reads 0 between the two.
